// File: rtl/armleo_axi_read_router.sv
// AXI4 read-channel router: decodes AR addresses onto client ports with one transaction in flight.
// Addresses outside every region are answered locally with a DECERR burst.
//
// state  | meaning
// IDLE   | no transaction in flight; AR decoded and passed through
// ACTIVE | R beats forwarded from client sel_idx until its rlast handshake
// DECERR | local DECERR beats, beat_cnt counts the remaining beats
module armleo_axi_read_router #(
    parameter int CLIENT_NUMBER = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH = 4,
    parameter logic [CLIENT_NUMBER*ADDR_WIDTH-1:0] REGION_BASE = {32'h4000_0000, 32'h0000_0000},
    parameter logic [CLIENT_NUMBER*ADDR_WIDTH-1:0] REGION_MASK = {32'hC000_0000, 32'hC000_0000}
) (
    input  logic                              clk,
    input  logic                              rst_n,

    input  logic                              upstream_axi_arvalid,
    output logic                              upstream_axi_arready,
    input  logic [ADDR_WIDTH-1:0]             upstream_axi_araddr,
    input  logic [7:0]                        upstream_axi_arlen,
    input  logic [2:0]                        upstream_axi_arsize,
    input  logic [1:0]                        upstream_axi_arburst,
    input  logic [ID_WIDTH-1:0]               upstream_axi_arid,
    input  logic                              upstream_axi_arlock,
    input  logic [2:0]                        upstream_axi_arprot,

    output logic                              upstream_axi_rvalid,
    input  logic                              upstream_axi_rready,
    output logic [1:0]                        upstream_axi_rresp,
    output logic                              upstream_axi_rlast,
    output logic [DATA_WIDTH-1:0]             upstream_axi_rdata,
    output logic [ID_WIDTH-1:0]               upstream_axi_rid,

    output logic [CLIENT_NUMBER-1:0]          downstream_axi_arvalid,
    input  logic [CLIENT_NUMBER-1:0]          downstream_axi_arready,
    output logic [CLIENT_NUMBER*ADDR_WIDTH-1:0] downstream_axi_araddr,
    output logic [CLIENT_NUMBER*8-1:0]        downstream_axi_arlen,
    output logic [CLIENT_NUMBER*3-1:0]        downstream_axi_arsize,
    output logic [CLIENT_NUMBER*2-1:0]        downstream_axi_arburst,
    output logic [CLIENT_NUMBER*ID_WIDTH-1:0] downstream_axi_arid,
    output logic [CLIENT_NUMBER-1:0]          downstream_axi_arlock,
    output logic [CLIENT_NUMBER*3-1:0]        downstream_axi_arprot,

    input  logic [CLIENT_NUMBER-1:0]          downstream_axi_rvalid,
    output logic [CLIENT_NUMBER-1:0]          downstream_axi_rready,
    input  logic [CLIENT_NUMBER*2-1:0]        downstream_axi_rresp,
    input  logic [CLIENT_NUMBER-1:0]          downstream_axi_rlast,
    input  logic [CLIENT_NUMBER*DATA_WIDTH-1:0] downstream_axi_rdata,
    input  logic [CLIENT_NUMBER*ID_WIDTH-1:0] downstream_axi_rid
);

    localparam int IDX_W = (CLIENT_NUMBER > 1) ? $clog2(CLIENT_NUMBER) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, DECERR} state_t;

    state_t              state;
    logic [IDX_W-1:0]    sel_idx;
    logic [7:0]          beat_cnt;
    logic [ID_WIDTH-1:0] err_id;

    logic                hit_any;
    logic [IDX_W-1:0]    dec_idx;

    assign downstream_axi_araddr  = {CLIENT_NUMBER{upstream_axi_araddr}};
    assign downstream_axi_arlen   = {CLIENT_NUMBER{upstream_axi_arlen}};
    assign downstream_axi_arsize  = {CLIENT_NUMBER{upstream_axi_arsize}};
    assign downstream_axi_arburst = {CLIENT_NUMBER{upstream_axi_arburst}};
    assign downstream_axi_arid    = {CLIENT_NUMBER{upstream_axi_arid}};
    assign downstream_axi_arlock  = {CLIENT_NUMBER{upstream_axi_arlock}};
    assign downstream_axi_arprot  = {CLIENT_NUMBER{upstream_axi_arprot}};

    // Scan from the top so the lowest matching region is the one left in dec_idx.
    always_comb begin
        hit_any = 1'b0;
        dec_idx = '0;
        for (int k = CLIENT_NUMBER - 1; k >= 0; k--) begin
            if ((upstream_axi_araddr & REGION_MASK[k*ADDR_WIDTH +: ADDR_WIDTH])
                    == REGION_BASE[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit_any = 1'b1;
                dec_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        downstream_axi_arvalid = '0;
        downstream_axi_rready  = '0;
        upstream_axi_arready   = 1'b0;
        upstream_axi_rvalid    = 1'b0;
        upstream_axi_rresp     = 2'b00;
        upstream_axi_rlast     = 1'b0;
        upstream_axi_rdata     = '0;
        upstream_axi_rid       = '0;
        case (state)
            IDLE: begin
                if (hit_any) begin
                    for (int k = 0; k < CLIENT_NUMBER; k++) begin
                        if (IDX_W'(k) == dec_idx) begin
                            downstream_axi_arvalid[k] = upstream_axi_arvalid;
                            upstream_axi_arready      = downstream_axi_arready[k];
                        end
                    end
                end else begin
                    upstream_axi_arready = upstream_axi_arvalid;
                end
            end
            ACTIVE: begin
                for (int k = 0; k < CLIENT_NUMBER; k++) begin
                    if (IDX_W'(k) == sel_idx) begin
                        upstream_axi_rvalid      = downstream_axi_rvalid[k];
                        upstream_axi_rresp       = downstream_axi_rresp[k*2 +: 2];
                        upstream_axi_rlast       = downstream_axi_rlast[k];
                        upstream_axi_rdata       = downstream_axi_rdata[k*DATA_WIDTH +: DATA_WIDTH];
                        upstream_axi_rid         = downstream_axi_rid[k*ID_WIDTH +: ID_WIDTH];
                        downstream_axi_rready[k] = upstream_axi_rready;
                    end
                end
            end
            DECERR: begin
                upstream_axi_rvalid = 1'b1;
                upstream_axi_rresp  = 2'b11;
                upstream_axi_rlast  = (beat_cnt == 8'd0);
                upstream_axi_rid    = err_id;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel_idx  <= '0;
            beat_cnt <= 8'd0;
            err_id   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (upstream_axi_arvalid && upstream_axi_arready) begin
                        if (hit_any) begin
                            sel_idx <= dec_idx;
                            state   <= ACTIVE;
                        end else begin
                            beat_cnt <= upstream_axi_arlen;
                            err_id   <= upstream_axi_arid;
                            state    <= DECERR;
                        end
                    end
                end
                ACTIVE: begin
                    if (upstream_axi_rvalid && upstream_axi_rready && upstream_axi_rlast)
                        state <= IDLE;
                end
                DECERR: begin
                    if (upstream_axi_rready) begin
                        if (beat_cnt == 8'd0)
                            state <= IDLE;
                        else
                            beat_cnt <= beat_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Withdrawing arvalid before the handshake is an AXI protocol violation from the host.
    ar_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (state == IDLE && upstream_axi_arvalid && !upstream_axi_arready) |=> upstream_axi_arvalid);

endmodule

// File: tb/tb_armleo_axi_read_router.sv
// Bench for armleo_axi_read_router: queue-based host/client model with per-cycle output compare
// and directed transactions pinned by literal expectations.
module tb_armleo_axi_read_router;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [3:0]  id;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        up_arvalid = 1'b0;
    logic        up_arready;
    logic [31:0] up_araddr = '0;
    logic [7:0]  up_arlen = '0;
    logic [2:0]  up_arsize = 3'd2;
    logic [1:0]  up_arburst = 2'd1;
    logic [3:0]  up_arid = '0;
    logic        up_arlock = 1'b0;
    logic [2:0]  up_arprot = '0;
    logic        up_rvalid;
    logic        up_rready = 1'b1;
    logic [1:0]  up_rresp;
    logic        up_rlast;
    logic [31:0] up_rdata;
    logic [3:0]  up_rid;

    logic [1:0]  d_arvalid;
    logic [1:0]  d_arready = 2'b11;
    logic [63:0] d_araddr;
    logic [15:0] d_arlen;
    logic [5:0]  d_arsize;
    logic [3:0]  d_arburst;
    logic [7:0]  d_arid;
    logic [1:0]  d_arlock;
    logic [5:0]  d_arprot;
    logic [1:0]  d_rvalid = '0;
    logic [1:0]  d_rready;
    logic [3:0]  d_rresp = '0;
    logic [1:0]  d_rlast = '0;
    logic [63:0] d_rdata = '0;
    logic [7:0]  d_rid = '0;

    armleo_axi_read_router dut (
        .clk(clk), .rst_n(rst_n),
        .upstream_axi_arvalid(up_arvalid), .upstream_axi_arready(up_arready),
        .upstream_axi_araddr(up_araddr), .upstream_axi_arlen(up_arlen),
        .upstream_axi_arsize(up_arsize), .upstream_axi_arburst(up_arburst),
        .upstream_axi_arid(up_arid), .upstream_axi_arlock(up_arlock),
        .upstream_axi_arprot(up_arprot),
        .upstream_axi_rvalid(up_rvalid), .upstream_axi_rready(up_rready),
        .upstream_axi_rresp(up_rresp), .upstream_axi_rlast(up_rlast),
        .upstream_axi_rdata(up_rdata), .upstream_axi_rid(up_rid),
        .downstream_axi_arvalid(d_arvalid), .downstream_axi_arready(d_arready),
        .downstream_axi_araddr(d_araddr), .downstream_axi_arlen(d_arlen),
        .downstream_axi_arsize(d_arsize), .downstream_axi_arburst(d_arburst),
        .downstream_axi_arid(d_arid), .downstream_axi_arlock(d_arlock),
        .downstream_axi_arprot(d_arprot),
        .downstream_axi_rvalid(d_rvalid), .downstream_axi_rready(d_rready),
        .downstream_axi_rresp(d_rresp), .downstream_axi_rlast(d_rlast),
        .downstream_axi_rdata(d_rdata), .downstream_axi_rid(d_rid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Default regions: client 0 owns [0, 0x4000_0000), client 1 owns [0x4000_0000, 0x8000_0000).
    function automatic int ref_decode(input logic [31:0] a);
        if (a < 32'h4000_0000) return 0;
        if (a < 32'h8000_0000) return 1;
        return -1;
    endfunction

    function automatic logic [31:0] f_data(input int k, input int i);
        logic [31:0] d;
        d = 32'h0000_00A0 + 32'(i);
        d[31:24] = 8'(k);
        return d;
    endfunction

    // model state
    beat_t cq [2][$];
    beat_t exp_q[$];
    beat_t hlog[$];
    int    hcyc[$];
    bit    busy = 1'b0;
    int    owner = -2;
    int    cyc_n = 0;
    int    last_r_cyc = -1;
    bit    c0_av, c1_av, c0_rr, c1_rr;

    // snapshot of what will happen at the next rising edge
    bit          s_rst = 1'b0;
    bit          s_ar_hs = 1'b0, s_r_hs = 1'b0;
    logic [31:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [3:0]  s_arid;
    bit    [1:0] s_dar_hs = '0, s_dr_hs = '0;
    logic [7:0]  s_dlen [2];
    logic [3:0]  s_did [2];
    beat_t       s_beat;
    bit          hold = 1'b0;
    logic [38:0] hold_pl;

    always @(negedge clk) begin
        int dk;
        logic [1:0] exp_dav, exp_drr;
        logic exp_arr, exp_rv;
        s_rst    = rst_n;
        s_ar_hs  = up_arvalid && up_arready;
        s_r_hs   = up_rvalid && up_rready;
        s_araddr = up_araddr;
        s_arlen  = up_arlen;
        s_arid   = up_arid;
        s_beat   = {up_rdata, up_rresp, up_rid, up_rlast};
        for (int k = 0; k < 2; k++) begin
            s_dar_hs[k] = d_arvalid[k] && d_arready[k];
            s_dr_hs[k]  = d_rvalid[k] && d_rready[k];
            s_dlen[k]   = d_arlen[k*8 +: 8];
            s_did[k]    = d_arid[k*4 +: 4];
        end
        if (rst_n && cyc_n > 0) begin
            dk = ref_decode(up_araddr);
            exp_dav = '0;
            if (!busy && up_arvalid && dk >= 0) exp_dav[dk] = 1'b1;
            exp_arr = busy ? 1'b0 : (dk >= 0 ? d_arready[dk] : up_arvalid);
            exp_rv  = busy && (owner == -1 || (owner >= 0 && cq[owner].size() > 0));
            exp_drr = '0;
            if (busy && owner >= 0) exp_drr[owner] = up_rready;
            chk("ds_arvalid", 64'(d_arvalid), 64'(exp_dav));
            chk("us_arready", 64'(up_arready), 64'(exp_arr));
            chk("us_rvalid", 64'(up_rvalid), 64'(exp_rv));
            chk("ds_rready", 64'(d_rready), 64'(exp_drr));
            if (up_rvalid && exp_q.size() > 0)
                chk("r_beat", 64'(s_beat), 64'(exp_q[0]));
            if (hold) begin
                chk("hold_rvalid", 64'(up_rvalid), 64'd1);
                chk("hold_payload", 64'(s_beat), 64'(hold_pl));
            end
            hold = up_rvalid && !up_rready;
            hold_pl = s_beat;
            if (d_arvalid[0]) c0_av = 1'b1;
            if (d_arvalid[1]) c1_av = 1'b1;
            if (d_rready[0])  c0_rr = 1'b1;
            if (d_rready[1])  c1_rr = 1'b1;
        end else begin
            hold = 1'b0;
        end
    end

    always @(posedge clk) begin
        int k;
        #1;
        cyc_n++;
        if (!s_rst) begin
            for (int j = 0; j < 2; j++) cq[j].delete();
            exp_q.delete();
            busy = 1'b0;
            owner = -2;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (s_dr_hs[j] && cq[j].size() > 0) void'(cq[j].pop_front());
                if (s_dar_hs[j])
                    for (int i = 0; i <= int'(s_dlen[j]); i++)
                        cq[j].push_back('{f_data(j, i), 2'b00, s_did[j], i == int'(s_dlen[j])});
            end
            if (s_r_hs) begin
                hlog.push_back(s_beat);
                hcyc.push_back(cyc_n);
                if (exp_q.size() == 0) begin
                    chk("r_unexpected", 64'(s_beat), 64'd0);
                end else begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        busy = 1'b0;
                        last_r_cyc = cyc_n;
                    end
                end
            end
            if (s_ar_hs) begin
                chk("ar_while_busy", 64'(busy), 64'd0);
                chk("ar_gap_after_last", 64'(cyc_n > last_r_cyc), 64'd1);
                k = ref_decode(s_araddr);
                busy = 1'b1;
                owner = k;
                for (int i = 0; i <= int'(s_arlen); i++)
                    exp_q.push_back(k >= 0 ? '{f_data(k, i), 2'b00, s_arid, i == int'(s_arlen)}
                                           : '{32'h0, 2'b11, s_arid, i == int'(s_arlen)});
            end
        end
        for (int j = 0; j < 2; j++) begin
            d_rvalid[j] = cq[j].size() > 0;
            if (cq[j].size() > 0) begin
                d_rdata[j*32 +: 32] = cq[j][0].data;
                d_rresp[j*2 +: 2]   = cq[j][0].resp;
                d_rid[j*4 +: 4]     = cq[j][0].id;
                d_rlast[j]          = cq[j][0].last;
            end else begin
                d_rdata[j*32 +: 32] = '0;
                d_rresp[j*2 +: 2]   = '0;
                d_rid[j*4 +: 4]     = '0;
                d_rlast[j]          = 1'b0;
            end
        end
        d_arready = {cyc_n[0], 1'b1};
    end

    task automatic host_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                             input bit bp, output int ar_wait);
        int  n0;
        bit  done, tog;
        n0 = hlog.size();
        @(posedge clk); #1;
        up_arvalid = 1'b1; up_araddr = addr; up_arlen = len; up_arid = id;
        done = 1'b0;
        ar_wait = 0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (up_arready) done = 1'b1; else ar_wait++;
            @(posedge clk); #1;
        end
        up_arvalid = 1'b0;
        if (!done) chk("ar_timeout", 64'd0, 64'd1);
        done = 1'b0;
        tog = 1'b1;
        for (int c = 0; c < 1200 && !done; c++) begin
            up_rready = bp ? tog : 1'b1;
            tog = !tog;
            @(posedge clk); #2;
            if (hlog.size() - n0 == int'(len) + 1) done = 1'b1;
        end
        up_rready = 1'b1;
        if (!done) chk("r_timeout", 64'(hlog.size() - n0), 64'(int'(len) + 1));
    endtask

    initial begin
        int n0, w, nacc;
        int acc_cyc [2];
        bit done;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_rvalid", 64'(up_rvalid), 64'd0);
        chk("reset_rready", 64'(d_rready), 64'd0);
        chk("reset_arvalid", 64'(d_arvalid), 64'd0);

        // mapped read, client 0
        c0_av = 0; c1_av = 0; c0_rr = 0; c1_rr = 0;
        n0 = hlog.size();
        host_read(32'h0000_0010, 8'd3, 4'd5, 1'b0, w);
        chk("t1_beats", 64'(hlog.size() - n0), 64'd4);
        if (hlog.size() - n0 == 4) begin
            chk("t1_first", 64'(hlog[n0]), 64'({32'h0000_00A0, 2'b00, 4'd5, 1'b0}));
            chk("t1_last", 64'(hlog[n0+3]), 64'({32'h0000_00A3, 2'b00, 4'd5, 1'b1}));
            chk("t1_mid_not_last", 64'(hlog[n0+2].last), 64'd0);
        end
        chk("t1_c1_arvalid", 64'(c1_av), 64'd0);
        @(negedge clk);
        chk("t1_idle_rvalid", 64'(up_rvalid), 64'd0);

        // mapped read, client 1
        c0_av = 0; c1_av = 0; c0_rr = 0; c1_rr = 0;
        n0 = hlog.size();
        host_read(32'h4000_0100, 8'd0, 4'd1, 1'b0, w);
        chk("t2_beats", 64'(hlog.size() - n0), 64'd1);
        if (hlog.size() - n0 == 1)
            chk("t2_beat", 64'(hlog[n0]), 64'({32'h0100_00A0, 2'b00, 4'd1, 1'b1}));
        chk("t2_c0_arvalid", 64'(c0_av), 64'd0);
        chk("t2_c1_arvalid", 64'(c1_av), 64'd1);
        chk("t2_c0_rready", 64'(c0_rr), 64'd0);

        // unmapped read
        c0_av = 0; c1_av = 0;
        n0 = hlog.size();
        host_read(32'h8000_0000, 8'd2, 4'd9, 1'b0, w);
        chk("t3_ar_wait", 64'(w), 64'd0);
        chk("t3_beats", 64'(hlog.size() - n0), 64'd3);
        if (hlog.size() - n0 == 3) begin
            chk("t3_b0", 64'(hlog[n0]), 64'({32'h0, 2'b11, 4'd9, 1'b0}));
            chk("t3_b1", 64'(hlog[n0+1]), 64'({32'h0, 2'b11, 4'd9, 1'b0}));
            chk("t3_b2", 64'(hlog[n0+2]), 64'({32'h0, 2'b11, 4'd9, 1'b1}));
        end
        chk("t3_no_arvalid", 64'({c1_av, c0_av}), 64'd0);

        // backpressure on client and DECERR bursts
        n0 = hlog.size();
        host_read(32'h0000_0400, 8'd5, 4'd2, 1'b1, w);
        chk("t4_client_beats", 64'(hlog.size() - n0), 64'd6);
        if (hlog.size() - n0 == 6)
            chk("t4_client_b4", 64'(hlog[n0+4].data), 64'h0000_00A4);
        n0 = hlog.size();
        host_read(32'hC000_0000, 8'd3, 4'd4, 1'b1, w);
        chk("t4_err_beats", 64'(hlog.size() - n0), 64'd4);

        // AR presented while a burst is active
        n0 = hlog.size();
        @(posedge clk); #1;
        up_arvalid = 1'b1; up_araddr = 32'h0000_0020; up_arlen = 8'd3; up_arid = 4'd2;
        nacc = 0;
        for (int c = 0; c < 100 && nacc < 2; c++) begin
            @(negedge clk);
            if (up_arvalid && up_arready) begin
                acc_cyc[nacc] = cyc_n + 1;
                nacc++;
            end
            @(posedge clk); #1;
            if (nacc == 1) begin up_araddr = 32'h4000_0200; up_arlen = 8'd1; up_arid = 4'd3; end
            if (nacc == 2) up_arvalid = 1'b0;
        end
        up_arvalid = 1'b0;
        chk("t5_ar_count", 64'(nacc), 64'd2);
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(posedge clk); #2;
            if (hlog.size() - n0 == 6) done = 1'b1;
        end
        chk("t5_beats", 64'(hlog.size() - n0), 64'd6);
        if (nacc == 2 && hlog.size() - n0 >= 4)
            chk("t5_second_after_last", 64'(acc_cyc[1] > hcyc[n0+3]), 64'd1);

        // long DECERR burst: 256 beats, rlast only on the final one
        n0 = hlog.size();
        host_read(32'hF000_0000, 8'd255, 4'd15, 1'b0, w);
        chk("t6_beats", 64'(hlog.size() - n0), 64'd256);
        if (hlog.size() - n0 == 256) begin
            chk("t6_b254_last", 64'(hlog[n0+254].last), 64'd0);
            chk("t6_b255_last", 64'(hlog[n0+255].last), 64'd1);
        end

        // reset during a DECERR burst
        n0 = hlog.size();
        @(posedge clk); #1;
        up_arvalid = 1'b1; up_araddr = 32'h9000_0000; up_arlen = 8'd7; up_arid = 4'd6;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (up_arready) done = 1'b1;
            @(posedge clk); #1;
        end
        up_arvalid = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(posedge clk); #2;
            if (hlog.size() - n0 == 1) done = 1'b1;
        end
        chk("t7_first_beat", 64'(hlog.size() - n0), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t7_rvalid_after_rst", 64'(up_rvalid), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t7_idle_rvalid", 64'(up_rvalid), 64'd0);
        chk("t7_no_more_beats", 64'(hlog.size() - n0), 64'd1);
        n0 = hlog.size();
        host_read(32'h0000_0030, 8'd1, 4'd7, 1'b0, w);
        chk("t7_fresh_beats", 64'(hlog.size() - n0), 64'd2);
        if (hlog.size() - n0 == 2)
            chk("t7_fresh_last", 64'(hlog[n0+1]), 64'({32'h0000_00A1, 2'b00, 4'd7, 1'b1}));

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
